// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and restoring divide,
// one bit per cycle, with divide-by-zero and signed-overflow cases resolved in the issue cycle.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall_ext,
    input  logic [6:0]      opcode_i,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            rd_we_i,
    input  logic [4:0]      rd_addr_i,
    output logic            stall_req,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            rd_we_o,
    output logic [4:0]      rd_addr_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_r;
    logic [CW-1:0]       cnt_r;
    logic [1:0]          op_r;
    logic                neg_r;
    logic                rneg_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     b_r;

    logic                is_md_s;
    logic                sgn1_s;
    logic                sgn2_s;
    logic                s1_s;
    logic                s2_s;
    logic [XLEN-1:0]     abs1_s;
    logic [XLEN-1:0]     abs2_s;
    logic                div0_s;
    logic                ovf_s;
    logic                fast_s;
    logic [XLEN-1:0]     fast_res_s;

    logic [XLEN:0]       mul_sum_s;
    logic [2*XLEN-1:0]   mul_next_s;
    logic [2*XLEN-1:0]   mul_prod_s;
    logic [XLEN-1:0]     mul_res_s;
    logic [XLEN:0]       div_sh_s;
    logic                div_ge_s;
    logic [XLEN-1:0]     div_sub_s;
    logic [2*XLEN-1:0]   div_next_s;
    logic [XLEN-1:0]     div_q_s;
    logic [XLEN-1:0]     div_r_s;
    logic [XLEN-1:0]     div_res_s;

    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    assign busy      = (state_r == MUL) || (state_r == DIV);
    assign stall_req = !rst && (((state_r == IDLE) && is_md_s) || busy);

    // Issue-side decode: operand signedness, magnitudes and the single-cycle special cases
    always_comb begin
        is_md_s = (opcode_i == 7'b0110011) && (funct7_i == 7'b0000001) && !flush;
        case (funct3_i)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sgn1_s = 1'b1;
                sgn2_s = 1'b1;
            end
            3'b010: begin
                sgn1_s = 1'b1;
                sgn2_s = 1'b0;
            end
            default: begin
                sgn1_s = 1'b0;
                sgn2_s = 1'b0;
            end
        endcase
        s1_s   = sgn1_s && rs1_data_i[XLEN-1];
        s2_s   = sgn2_s && rs2_data_i[XLEN-1];
        abs1_s = s1_s ? -rs1_data_i : rs1_data_i;
        abs2_s = s2_s ? -rs2_data_i : rs2_data_i;
        div0_s = (rs2_data_i == ZERO);
        ovf_s  = sgn2_s && (rs1_data_i == MINV) && (rs2_data_i == ONES);
        fast_s = funct3_i[2] && (div0_s || ovf_s);
        if (div0_s) begin
            fast_res_s = funct3_i[1] ? rs1_data_i : ONES;
        end else if (ovf_s) begin
            fast_res_s = funct3_i[1] ? ZERO : rs1_data_i;
        end else begin
            fast_res_s = ZERO;
        end
    end

    // One iteration step of each engine plus the sign-corrected result of the final step
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
        mul_prod_s = neg_r ? -mul_next_s : mul_next_s;
        mul_res_s  = (op_r == 2'b00) ? mul_prod_s[XLEN-1:0] : mul_prod_s[2*XLEN-1:XLEN];

        div_sh_s   = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        div_ge_s   = (div_sh_s >= {1'b0, b_r});
        div_sub_s  = div_sh_s[XLEN-1:0] - b_r;
        div_next_s = {(div_ge_s ? div_sub_s : div_sh_s[XLEN-1:0]), acc_r[XLEN-2:0], div_ge_s};
        div_q_s    = div_next_s[XLEN-1:0];
        div_r_s    = div_next_s[2*XLEN-1:XLEN];
        if (op_r[1]) begin
            div_res_s = rneg_r ? -div_r_s : div_r_s;
        end else begin
            div_res_s = neg_r ? -div_q_s : div_q_s;
        end
    end

    // Control FSM; flush wins over issue and over the downstream hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            op_r         <= 2'b00;
            neg_r        <= 1'b0;
            rneg_r       <= 1'b0;
            acc_r        <= {(2*XLEN){1'b0}};
            b_r          <= ZERO;
            result       <= ZERO;
            result_valid <= 1'b0;
            rd_we_o      <= 1'b0;
            rd_addr_o    <= 5'd0;
        end else if (flush) begin
            state_r      <= IDLE;
            result_valid <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (is_md_s) begin
                        op_r      <= funct3_i[1:0];
                        rd_we_o   <= rd_we_i;
                        rd_addr_o <= rd_addr_i;
                        neg_r     <= s1_s ^ s2_s;
                        rneg_r    <= s1_s;
                        cnt_r     <= {CW{1'b0}};
                        if (fast_s) begin
                            result       <= fast_res_s;
                            result_valid <= 1'b1;
                            state_r      <= DONE;
                        end else if (funct3_i[2]) begin
                            acc_r   <= {ZERO, abs1_s};
                            b_r     <= abs2_s;
                            state_r <= DIV;
                        end else begin
                            acc_r   <= {ZERO, abs2_s};
                            b_r     <= abs1_s;
                            state_r <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc_r <= mul_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(XLEN-1)) begin
                        result       <= mul_res_s;
                        result_valid <= 1'b1;
                        state_r      <= DONE;
                    end
                end
                DIV: begin
                    acc_r <= div_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(XLEN-1)) begin
                        result       <= div_res_s;
                        result_valid <= 1'b1;
                        state_r      <= DONE;
                    end
                end
                DONE: begin
                    if (!stall_ext) begin
                        result_valid <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    result_valid <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed plus light random bench for ex_muldiv with an expected-result queue.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        stall_ext;
    logic [6:0]  opcode_i;
    logic [6:0]  funct7_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        rd_we_i;
    logic [4:0]  rd_addr_i;
    logic        stall_req;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;
    logic        rd_we_o;
    logic [4:0]  rd_addr_o;

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_ext(stall_ext),
        .opcode_i(opcode_i), .funct7_i(funct7_i), .funct3_i(funct3_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i),
        .stall_req(stall_req), .busy(busy), .result(result),
        .result_valid(result_valid), .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o)
    );

    always #5 clk = ~clk;

    localparam logic [6:0]  OP_R  = 7'b0110011;
    localparam logic [6:0]  F7_M  = 7'b0000001;
    localparam logic [31:0] MINV  = 32'h8000_0000;
    localparam logic [31:0] ONES  = 32'hFFFF_FFFF;

    int          total = 0;
    int          bad = 0;
    int          add_viol = 0;
    logic [37:0] sb_q[$];
    logic [31:0] last_res;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_add();
        opcode_i   = OP_R;
        funct7_i   = 7'h00;
        funct3_i   = 3'b000;
        rs1_data_i = 32'd11;
        rs2_data_i = 32'd22;
        rd_we_i    = 1'b1;
        rd_addr_i  = 5'd3;
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'h0) return ONES;
                if (a == MINV && b == ONES) return a;
                return $signed(a) / $signed(b);
            end
            3'b101: return (b == 32'h0) ? ONES : a / b;
            3'b110: begin
                if (b == 32'h0) return a;
                if (a == MINV && b == ONES) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    // Issue one op, wait for its result, check latency/stall/scoreboard, optionally hold in DONE
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic we, input logic [31:0] exp,
                          input int exp_lat, input int hold);
        int          lat;
        logic        st_ok;
        logic [37:0] e;
        opcode_i   = OP_R;
        funct7_i   = F7_M;
        funct3_i   = f3;
        rs1_data_i = a;
        rs2_data_i = b;
        rd_we_i    = we;
        rd_addr_i  = rd;
        stall_ext  = (hold > 0);
        sb_q.push_back({we, rd, exp});
        #1;
        st_ok = (stall_req === 1'b1);
        lat = 0;
        do begin
            tick();
            lat++;
            #1;
            if (result_valid !== 1'b1 && stall_req !== 1'b1) st_ok = 1'b0;
        end while (result_valid !== 1'b1 && lat < 40);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_stall"}, st_ok, 1'b1);
        chk({tag, "_done_stall"}, stall_req, 1'b0);
        e = sb_q.pop_front();
        last_res = e[31:0];
        chk({tag, "_res"}, {result_valid, rd_we_o, rd_addr_o, result}, {1'b1, e});
        for (int k = 1; k <= hold; k++) begin
            tick();
            #1;
            chk({tag, "_hold"}, {result_valid, busy, result}, {1'b1, 1'b0, e[31:0]});
        end
        stall_ext = 1'b0;
        tick();
        #1;
        chk({tag, "_ret"}, {result_valid, busy}, 2'b00);
        set_add();
    endtask

    // Whenever an ADD sits on the inputs outside flush/reset, the unit must stay transparent
    always @(negedge clk) begin
        if (!rst && !flush && opcode_i == OP_R && funct7_i == 7'h00 &&
            (stall_req !== 1'b0 || result_valid !== 1'b0))
            add_viol++;
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic        seen;
        int          lat;
        rst = 1'b1;
        flush = 1'b0;
        stall_ext = 1'b0;
        last_res = 32'h0;
        set_add();
        tick();
        tick();
        chk("reset_vals", {result, result_valid, busy, stall_req, rd_we_o, rd_addr_o}, 41'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("add_idle", {stall_req, result_valid, busy}, 3'b000);
        end

        run_op("mul",      3'b000, 32'd7,        32'hFFFF_FFFD, 5'd1,  1'b1, 32'hFFFF_FFEB, 33, 0);
        run_op("mulh",     3'b001, MINV,         MINV,          5'd2,  1'b1, 32'h4000_0000, 33, 0);
        run_op("mulhsu",   3'b010, MINV,         MINV,          5'd3,  1'b1, 32'hC000_0000, 33, 0);
        run_op("mulhu",    3'b011, MINV,         MINV,          5'd4,  1'b1, 32'h4000_0000, 33, 0);
        run_op("div_ovf",  3'b100, MINV,         ONES,          5'd5,  1'b1, 32'h8000_0000, 1,  0);
        run_op("rem_ovf",  3'b110, MINV,         ONES,          5'd6,  1'b1, 32'h0,         1,  0);
        run_op("divu_z",   3'b101, 32'd5,        32'd0,         5'd7,  1'b1, ONES,          1,  0);
        run_op("remu_z",   3'b111, 32'd5,        32'd0,         5'd8,  1'b1, 32'd5,         1,  0);
        run_op("div_z",    3'b100, 32'h123,      32'd0,         5'd9,  1'b1, ONES,          1,  0);
        run_op("rem_z",    3'b110, 32'h123,      32'd0,         5'd10, 1'b1, 32'h123,       1,  0);
        run_op("rem_neg",  3'b110, 32'hFFFF_FF9C, 32'd7,        5'd11, 1'b1, 32'hFFFF_FFFE, 33, 0);
        run_op("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2,        5'd0,  1'b0, 32'hFFFF_FFFD, 33, 0);
        run_op("divu_big", 3'b101, ONES,         32'd3,         5'd12, 1'b1, 32'h5555_5555, 33, 0);
        run_op("mul_hold", 3'b000, 32'd3,        32'd4,         5'd13, 1'b1, 32'd12,        33, 3);

        for (int i = 0; i < 8; i++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: a = MINV;
                1: a = 32'($urandom_range(0, 100));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: b = ONES;
                1: b = 32'($urandom_range(0, 9));
                default: b = $urandom;
            endcase
            lat = (f3[2] && (b == 32'h0 || (!f3[0] && a == MINV && b == ONES))) ? 1 : 33;
            run_op("rand", f3, a, b, 5'($urandom_range(1, 31)), 1'b1, model(f3, a, b), lat, 0);
        end

        // Flush partway through a divide: no result, previous result retained
        opcode_i = OP_R;  funct7_i = F7_M;  funct3_i = 3'b100;
        rs1_data_i = 32'd1000;  rs2_data_i = 32'd7;  rd_addr_i = 5'd14;
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        set_add();
        tick();
        flush = 1'b0;
        #1;
        chk("flush_idle", {result_valid, busy, stall_req, result}, {3'b000, last_res});
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (result_valid !== 1'b0) seen = 1'b1;
        end
        chk("flush_noval", seen, 1'b0);

        // Asynchronous reset in the middle of a divide
        opcode_i = OP_R;  funct7_i = F7_M;  funct3_i = 3'b101;
        rs1_data_i = 32'd999;  rs2_data_i = 32'd4;  rd_addr_i = 5'd15;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", {result, result_valid, busy, stall_req, rd_we_o, rd_addr_o}, 41'h0);
        set_add();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst", {stall_req, result_valid, busy}, 3'b000);

        chk("add_passthru", add_viol, 0);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
